// File: rtl/ram_sp_384x32_arb.sv
// ram_sp_384x32_arb: two-requester arbiter/sequencer for a shared 384x32 single-port SRAM.
// Round-robin between requesters A and B, with a bounded lock (burst) option. Read data returns
// with a per-requester valid one cycle after the grant. Out-of-range addresses never reach the
// SRAM. They are still granted, and they set the sticky err_o flag.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   {a,b}_req_i/_wr_i          access request, 1 = write / 0 = read
//   {a,b}_adr_i/_dat_i         address and write data
//   {a,b}_lock_i               keep ownership for the next access
//   {a,b}_gnt_o                access accepted this cycle
//   {a,b}_rd_vld_o             read data valid, one cycle after the read grant
//   rd_dat_o                   shared read data (zero for out-of-range reads)
//   ram_*                      SRAM address / enables / write data / read data
//   err_o, err_clr_i           sticky out-of-range flag and its clear
module ram_sp_384x32_arb #(
    parameter int unsigned ADR_WD    = 9,
    parameter int unsigned DAT_WD    = 32,
    parameter int unsigned DEPTH     = 384,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              a_req_i,
    input  logic              a_wr_i,
    input  logic [ADR_WD-1:0] a_adr_i,
    input  logic [DAT_WD-1:0] a_dat_i,
    input  logic              a_lock_i,
    output logic              a_gnt_o,
    output logic              a_rd_vld_o,
    input  logic              b_req_i,
    input  logic              b_wr_i,
    input  logic [ADR_WD-1:0] b_adr_i,
    input  logic [DAT_WD-1:0] b_dat_i,
    input  logic              b_lock_i,
    output logic              b_gnt_o,
    output logic              b_rd_vld_o,
    output logic [DAT_WD-1:0] rd_dat_o,
    output logic [ADR_WD-1:0] ram_adr_o,
    output logic              ram_wr_ena_o,
    output logic [DAT_WD-1:0] ram_wr_dat_o,
    output logic              ram_rd_ena_o,
    input  logic [DAT_WD-1:0] ram_rd_dat_i,
    output logic              err_o,
    input  logic              err_clr_i
);

    localparam logic [3:0]      MaxBurst = 4'(MAX_BURST);
    localparam logic [ADR_WD:0] DepthW   = (ADR_WD+1)'(DEPTH);

    // last_gnt: 0 = A, 1 = B. While owner_vld is set, the owner is always last_gnt.
    logic       last_gnt_q, last_gnt_d;
    logic       owner_vld_q, owner_vld_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rd_pend_a_q, rd_pend_a_d;
    logic       rd_pend_b_q, rd_pend_b_d;
    logic       rd_oor_q, rd_oor_d;
    logic       err_q, err_d;

    logic              owner_req;
    logic              lock_act;
    logic              gnt_a, gnt_b, any_gnt;
    logic              sel_wr, sel_lock, in_range;
    logic [ADR_WD-1:0] sel_adr;

    always_comb begin
        owner_req = last_gnt_q ? b_req_i : a_req_i;
        // An active lock forces the grant to the owner until the burst budget runs out.
        lock_act  = owner_vld_q && owner_req && (burst_cnt_q < MaxBurst);

        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rstn) begin
            if (lock_act) begin
                gnt_a = !last_gnt_q;
                gnt_b = last_gnt_q;
            end else if (a_req_i && b_req_i) begin
                gnt_a = last_gnt_q;
                gnt_b = !last_gnt_q;
            end else begin
                gnt_a = a_req_i;
                gnt_b = b_req_i;
            end
        end
        any_gnt = gnt_a || gnt_b;

        sel_wr   = gnt_b ? b_wr_i   : a_wr_i;
        sel_adr  = gnt_b ? b_adr_i  : a_adr_i;
        sel_lock = gnt_b ? b_lock_i : a_lock_i;
        in_range = {1'b0, sel_adr} < DepthW;
    end

    always_comb begin
        a_gnt_o      = gnt_a;
        b_gnt_o      = gnt_b;
        ram_wr_ena_o = any_gnt && in_range && sel_wr;
        ram_rd_ena_o = any_gnt && in_range && !sel_wr;
        // Bus idles on requester A whenever nothing legal is issued.
        ram_adr_o    = (gnt_b && in_range) ? b_adr_i : a_adr_i;
        ram_wr_dat_o = (gnt_b && in_range) ? b_dat_i : a_dat_i;
        a_rd_vld_o   = rd_pend_a_q && rstn;
        b_rd_vld_o   = rd_pend_b_q && rstn;
        rd_dat_o     = rd_oor_q ? '0 : ram_rd_dat_i;
        err_o        = err_q && rstn;
    end

    always_comb begin
        last_gnt_d  = last_gnt_q;
        owner_vld_d = 1'b0;
        burst_cnt_d = 4'd0;
        if (any_gnt) begin
            last_gnt_d = gnt_b;
            if (sel_lock) begin
                owner_vld_d = 1'b1;
                // lock_act with a grant means the granted requester is the current owner.
                burst_cnt_d = lock_act ? burst_cnt_q + 4'd1 : 4'd1;
            end
        end
        rd_pend_a_d = gnt_a && !a_wr_i;
        rd_pend_b_d = gnt_b && !b_wr_i;
        rd_oor_d    = any_gnt && !sel_wr && !in_range;
        // Set wins over a simultaneous clear.
        if (any_gnt && !in_range) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_gnt_q  <= 1'b1;
            owner_vld_q <= 1'b0;
            burst_cnt_q <= 4'd0;
            rd_pend_a_q <= 1'b0;
            rd_pend_b_q <= 1'b0;
            rd_oor_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            owner_vld_q <= owner_vld_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_a_q <= rd_pend_a_d;
            rd_pend_b_q <= rd_pend_b_d;
            rd_oor_q    <= rd_oor_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ram_sp_384x32_arb.sv
// Randomised scoreboard bench for ram_sp_384x32_arb with a behavioural SRAM and reference model.
module tb_ram_sp_384x32_arb;

    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_req_i, a_wr_i, a_lock_i, b_req_i, b_wr_i, b_lock_i;
    logic [8:0]  a_adr_i, b_adr_i, ram_adr_o;
    logic [31:0] a_dat_i, b_dat_i, rd_dat_o, ram_wr_dat_o, ram_rd_dat_i;
    logic        a_gnt_o, a_rd_vld_o, b_gnt_o, b_rd_vld_o;
    logic        ram_wr_ena_o, ram_rd_ena_o, err_o, err_clr_i;

    ram_sp_384x32_arb dut (
        .clk(clk), .rstn(rstn),
        .a_req_i(a_req_i), .a_wr_i(a_wr_i), .a_adr_i(a_adr_i), .a_dat_i(a_dat_i),
        .a_lock_i(a_lock_i), .a_gnt_o(a_gnt_o), .a_rd_vld_o(a_rd_vld_o),
        .b_req_i(b_req_i), .b_wr_i(b_wr_i), .b_adr_i(b_adr_i), .b_dat_i(b_dat_i),
        .b_lock_i(b_lock_i), .b_gnt_o(b_gnt_o), .b_rd_vld_o(b_rd_vld_o),
        .rd_dat_o(rd_dat_o), .ram_adr_o(ram_adr_o), .ram_wr_ena_o(ram_wr_ena_o),
        .ram_wr_dat_o(ram_wr_dat_o), .ram_rd_ena_o(ram_rd_ena_o), .ram_rd_dat_i(ram_rd_dat_i),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Behavioural SRAM: one-cycle read latency, unwritten words hold init_val.
    logic [31:0] sram [512];
    bit          written [512];
    always @(posedge clk) begin
        if (ram_wr_ena_o) begin
            sram[ram_adr_o]    <= ram_wr_dat_o;
            written[ram_adr_o] <= 1'b1;
        end
        if (ram_rd_ena_o) begin
            ram_rd_dat_i <= written[ram_adr_o] ? sram[ram_adr_o] : init_val(int'(ram_adr_o));
        end
    end

    typedef struct {
        int          cyc;
        bit          who;
        logic [31:0] dat;
    } rd_exp_t;

    typedef struct {
        bit          vld;
        bit          wr;
        bit          lock;
        logic [8:0]  adr;
        logic [31:0] dat;
    } txn_t;

    rd_exp_t exp_q[$];
    int      n_cmp = 0;
    int      n_err = 0;
    int      cyc   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic txn_t new_txn(input bit force_lock, input bit lock_val);
        txn_t t;
        int   r;
        t.vld = 1'b1;
        t.wr  = $urandom_range(0, 1) == 1;
        r     = $urandom_range(0, 9);
        if (r < 6)      t.adr = 9'($urandom_range(0, 15));
        else if (r < 8) t.adr = 9'($urandom_range(0, 383));
        else            t.adr = 9'($urandom_range(384, 511));
        t.dat  = $urandom;
        t.lock = force_lock ? lock_val : ($urandom_range(0, 9) < 4);
        return t;
    endfunction

    // Monitor: every cycle, compares read valids and data against the scoreboard queue.
    initial begin
        bit exp_vld, exp_who;
        forever begin
            @(negedge clk);
            #3;
            if (cyc > 0) begin
                exp_vld = exp_q.size() > 0 && exp_q[0].cyc == cyc - 1;
                exp_who = exp_vld ? exp_q[0].who : 1'b0;
                check("rd_vld", {62'd0, b_rd_vld_o, a_rd_vld_o},
                      {62'd0, exp_vld && exp_who, exp_vld && !exp_who});
                if (exp_vld) begin
                    check("rd_dat", {32'd0, rd_dat_o}, {32'd0, exp_q[0].dat});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus plus reference model of arbitration, lock budget and error flag.
    initial begin
        logic [31:0] ref_mem [512];
        txn_t        ta, tb_t, tg;
        bit          m_last, m_own, m_err, owner_active, oor;
        int          m_cnt, who;

        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
        ta = '{default: '0};
        tb_t = '{default: '0};
        m_last = 1'b1; m_own = 1'b0; m_err = 1'b0; m_cnt = 0;
        rstn = 1'b0; err_clr_i = 1'b0;
        a_req_i = 0; a_wr_i = 0; a_adr_i = 0; a_dat_i = 0; a_lock_i = 0;
        b_req_i = 0; b_wr_i = 0; b_adr_i = 0; b_dat_i = 0; b_lock_i = 0;

        for (int k = 1; k <= NCYC; k++) begin
            @(negedge clk);
            #1;
            cyc = k;
            rstn = !(k <= 3 || (k > 300 && $urandom_range(0, 249) == 0));
            if (!rstn) exp_q.delete();

            // Cycles up to 300: both requesters always busy, A always locking (burst budget).
            if (!ta.vld && (k <= 300 || $urandom_range(0, 9) < 6))
                ta = new_txn(k <= 300, 1'b1);
            if (!tb_t.vld && (k <= 300 || $urandom_range(0, 9) < 6))
                tb_t = new_txn(k <= 300, 1'b0);
            a_req_i = ta.vld;   a_wr_i = ta.wr;   a_adr_i = ta.adr;
            a_dat_i = ta.dat;   a_lock_i = ta.lock;
            b_req_i = tb_t.vld; b_wr_i = tb_t.wr; b_adr_i = tb_t.adr;
            b_dat_i = tb_t.dat; b_lock_i = tb_t.lock;
            err_clr_i = $urandom_range(0, 7) == 0;
            #1;

            owner_active = m_own && (m_last ? tb_t.vld : ta.vld) && m_cnt < 8;
            if (!rstn)                    who = -1;
            else if (owner_active)        who = m_last ? 1 : 0;
            else if (ta.vld && tb_t.vld)  who = m_last ? 0 : 1;
            else if (ta.vld)              who = 0;
            else if (tb_t.vld)            who = 1;
            else                          who = -1;

            tg  = (who == 1) ? tb_t : ta;
            oor = tg.adr >= 9'd384;
            check("gnt", {62'd0, b_gnt_o, a_gnt_o}, {62'd0, who == 1, who == 0});
            check("ram_ena", {62'd0, ram_wr_ena_o, ram_rd_ena_o},
                  {62'd0, who >= 0 && !oor && tg.wr, who >= 0 && !oor && !tg.wr});
            if (who >= 0 && !oor) check("ram_adr", {55'd0, ram_adr_o}, {55'd0, tg.adr});
            if (who >= 0 && !oor && tg.wr)
                check("ram_wr_dat", {32'd0, ram_wr_dat_o}, {32'd0, tg.dat});
            check("err_o", {63'd0, err_o}, {63'd0, rstn && m_err});

            if (!rstn) begin
                m_last = 1'b1; m_own = 1'b0; m_cnt = 0; m_err = 1'b0;
            end else begin
                if (who >= 0) begin
                    if (tg.wr && !oor) ref_mem[tg.adr] = tg.dat;
                    if (!tg.wr)
                        exp_q.push_back('{cyc: k, who: who == 1,
                                          dat: oor ? 32'd0 : ref_mem[tg.adr]});
                    if (tg.lock) begin
                        m_cnt = owner_active ? m_cnt + 1 : 1;
                        m_own = 1'b1;
                    end else begin
                        m_cnt = 0;
                        m_own = 1'b0;
                    end
                    m_last = who == 1;
                    if (who == 1) tb_t.vld = 1'b0;
                    else          ta.vld = 1'b0;
                end else begin
                    m_own = 1'b0;
                    m_cnt = 0;
                end
                if (who >= 0 && oor)  m_err = 1'b1;
                else if (err_clr_i)   m_err = 1'b0;
            end
        end

        @(negedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
